// File: rtl/sm83_pkg.sv
// Shared SM83 types and constants used by the memory-side blocks.
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  localparam addr_t DMA_REG_ADDR = 16'hFF46;
  localparam addr_t OAM_BASE     = 16'hFE00;
  localparam int    OAM_LEN      = 160;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine and single-port memory arbiter: forwards CPU traffic when idle,
// copies 160 bytes into OAM on a 0xFF46 write. OAM_DMA_START_DELAY_EN adds the START cycle.
module oam_dma
  import sm83_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_r_addr,
  input  logic [15:0] cpu_w_addr,
  input  logic [7:0]  cpu_w_data,
  output logic [7:0]  cpu_r_data,
  output logic        mem_wen,
  output logic [15:0] mem_r_addr,
  output logic [15:0] mem_w_addr,
  output logic [7:0]  mem_w_data,
  input  logic [7:0]  mem_r_data,
  output logic        dma_busy
);

`ifdef OAM_DMA_START_DELAY_EN
  localparam dma_state_t LAUNCH = START;
`else
  localparam dma_state_t LAUNCH = XFER;
`endif

  localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic       reg_wr;
  logic [7:0] eff_src;

  assign reg_wr   = cpu_wen && (cpu_w_addr == DMA_REG_ADDR);
  // Pages 0xE0 and up are the echo of work RAM 0x20 pages lower.
  assign eff_src  = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
  assign dma_busy = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_hi_d   = src_hi_q;
    mem_r_addr = cpu_r_addr;
    mem_w_addr = cpu_w_addr;
    mem_w_data = cpu_w_data;
    mem_wen    = 1'b0;
    cpu_r_data = 8'hFF;

    case (state_q)
      IDLE: begin
        mem_wen    = cpu_wen && !reg_wr;
        cpu_r_data = mem_r_data;
      end
      START: begin
        state_d = XFER;
        idx_d   = 8'd0;
      end
      XFER: begin
        mem_r_addr = {eff_src, idx_q};
        mem_w_addr = OAM_BASE + {8'h00, idx_q};
        mem_w_data = mem_r_data;
        // A reset asserted mid-copy must stop writes in that very cycle.
        mem_wen    = !rst;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = 8'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 8'd0;
      end
    endcase

    if (cpu_r_addr == DMA_REG_ADDR)
      cpu_r_data = src_hi_q;

    // Register write starts or restarts; the current byte still commits this cycle.
    if (reg_wr) begin
      src_hi_d = cpu_w_data;
      state_d  = LAUNCH;
      idx_d    = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 8'd0;
      src_hi_q <= 8'hFF;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      src_hi_q <= src_hi_d;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma with a behavioural memory image as reference.
module tb_oam_dma;
  import sm83_pkg::*;

`ifdef OAM_DMA_START_DELAY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int BUSY_LEN = 160 + OFS;

  logic        clk = 1'b0;
  logic        rst, cpu_wen, mem_wen, dma_busy;
  logic [15:0] cpu_r_addr, cpu_w_addr, mem_r_addr, mem_w_addr;
  logic [7:0]  cpu_w_data, cpu_r_data, mem_w_data, mem_r_data;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int n_chk = 0;
  int n_err = 0;

  oam_dma u_dut (
    .clk(clk), .rst(rst), .cpu_wen(cpu_wen), .cpu_r_addr(cpu_r_addr),
    .cpu_w_addr(cpu_w_addr), .cpu_w_data(cpu_w_data), .cpu_r_data(cpu_r_data),
    .mem_wen(mem_wen), .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wen) mem[mem_w_addr] <= mem_w_data;
  assign mem_r_data = mem[mem_r_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int src_base(input logic [7:0] s);
    int p;
    p = int'(s);
    if (p >= 'hE0) p = p - 'h20;
    return p * 256;
  endfunction

  task automatic ref_copy(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) ref_mem['hFE00 + i] = ref_mem[src_base(s) + i];
  endtask

  task automatic fill_page(input logic [7:0] s);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      mem[src_base(s) + i]     = v;
      ref_mem[src_base(s) + i] = v;
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d, output logic wen_seen);
    cpu_w_addr = a; cpu_w_data = d; cpu_wen = 1'b1;
    #1 wen_seen = mem_wen;
    @(negedge clk);
    cpu_wen = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    cpu_r_addr = a;
    #1 d = cpu_r_data;
  endtask

  // Counts busy cycles from the current negedge; optional random CPU traffic.
  task automatic wait_idle(input bit rand_ops, input logic [7:0] src, output int n);
    logic [15:0] a;
    n = 0;
    while (dma_busy && n < 400) begin
      n++;
      if (rand_ops) begin
        a = 16'($urandom);
        if (a == DMA_REG_ADDR) a = 16'hC000;
        cpu_w_addr = a;
        cpu_w_data = 8'($urandom);
        cpu_wen    = 1'($urandom_range(0, 1));
        cpu_r_addr = ($urandom_range(0, 3) == 0) ? DMA_REG_ADDR : 16'($urandom);
        #1 chk("busy_rd", cpu_r_data, (cpu_r_addr == DMA_REG_ADDR) ? src : 8'hFF);
      end
      @(negedge clk);
    end
    cpu_wen = 1'b0;
  endtask

  initial begin
    logic       w;
    logic [7:0] d, v, pg;
    int         n;
    rst = 1'b1; cpu_wen = 1'b0; cpu_r_addr = '0; cpu_w_addr = '0; cpu_w_data = '0;
    for (int a = 0; a < 65536; a++) begin
      v = 8'($urandom);
      mem[a] = v; ref_mem[a] = v;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle pass-through
    #1 chk("rst_busy", dma_busy, 0);
    cpu_rd(DMA_REG_ADDR, d); chk("rst_src_hi", d, 8'hFF);
    cpu_rd(16'h1234, d);     chk("idle_rd", d, ref_mem[16'h1234]);
    chk("idle_raddr", mem_r_addr, 16'h1234);
    @(negedge clk);
    cpu_wr(16'hC123, 8'hAB, w); chk("idle_wen", w, 1);
    ref_mem[16'hC123] = 8'hAB;
    cpu_rd(16'hC123, d); chk("idle_rdback", d, 8'hAB);

    // Basic transfer
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + i] = 8'(i) ^ 8'h5A; ref_mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
    end
    cpu_wr(DMA_REG_ADDR, 8'hC0, w); chk("ff46_no_wen", w, 0);
    ref_copy(8'hC0, 160);
    wait_idle(1'b0, 8'hC0, n); chk("basic_busy_len", n, BUSY_LEN);
    chk("basic_oam5", mem[16'hFE05], 8'h05 ^ 8'h5A);
    check_mem("basic_mem");

    // Echo mirror with random CPU traffic
    fill_page(8'hC1);
    cpu_wr(DMA_REG_ADDR, 8'hE1, w);
    ref_copy(8'hE1, 160);
    wait_idle(1'b1, 8'hE1, n); chk("echo_busy_len", n, BUSY_LEN);
    check_mem("echo_mem");
    cpu_rd(DMA_REG_ADDR, d); chk("echo_readback", d, 8'hE1);
    @(negedge clk);

    // Bus lock
    cpu_wr(DMA_REG_ADDR, 8'hC0, w);
    ref_copy(8'hC0, 160);
    repeat (3) @(negedge clk);
    cpu_w_addr = 16'hC000; cpu_w_data = 8'h33; cpu_wen = 1'b1; cpu_r_addr = 16'h8000;
    #1 chk("lock_rd", cpu_r_data, 8'hFF);
    @(negedge clk);
    cpu_wen = 1'b0;
    wait_idle(1'b0, 8'hC0, n); chk("lock_busy_len", n, BUSY_LEN - 4);
    cpu_rd(16'h8000, d); chk("lock_rd_after", d, ref_mem[16'h8000]);
    check_mem("lock_mem");
    @(negedge clk);

    // Random pages
    repeat (4) begin
      pg = ($urandom_range(0, 1) == 0) ? 8'($urandom_range('hC0, 'hDF))
                                       : 8'($urandom_range('hE0, 'hFD));
      fill_page(pg);
      cpu_wr(DMA_REG_ADDR, pg, w); chk("rand_no_wen", w, 0);
      ref_copy(pg, 160);
      wait_idle(1'b1, pg, n); chk("rand_busy_len", n, BUSY_LEN);
      check_mem("rand_mem");
    end

    // Restart on the last byte
    fill_page(8'hC0); fill_page(8'hD0);
    cpu_wr(DMA_REG_ADDR, 8'hC0, w);
    ref_copy(8'hC0, 160);
    repeat (159 + OFS) @(negedge clk);
    cpu_w_addr = DMA_REG_ADDR; cpu_w_data = 8'hD0; cpu_wen = 1'b1;
    #1 chk("rs_last_waddr", mem_w_addr, 16'hFE9F);
    chk("rs_last_wen", mem_wen, 1);
    @(negedge clk);
    cpu_wen = 1'b0;
    chk("rs_byte159", mem[16'hFE9F], ref_mem[16'hC09F]);
    chk("rs_busy", dma_busy, 1);
    ref_copy(8'hD0, 160);
    wait_idle(1'b0, 8'hD0, n); chk("rs_busy_len", n, BUSY_LEN);
    check_mem("rs_mem");

    // Reset mid-transfer at idx 80
    fill_page(8'hC0);
    cpu_wr(DMA_REG_ADDR, 8'hC0, w);
    repeat (80 + OFS) @(negedge clk);
    #1 chk("rst80_waddr", mem_w_addr, 16'hFE50);
    rst = 1'b1;
    #1 chk("rst80_wen", mem_wen, 0);
    @(negedge clk);
    chk("rst80_busy", dma_busy, 0);
    rst = 1'b0;
    ref_copy(8'hC0, 80);
    check_mem("rst80_mem");
    cpu_rd(DMA_REG_ADDR, d); chk("rst80_src_hi", d, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
